vga_fetch_ctrl: RTL and testbench

Display-side controller for the 8 KiB VRAM. It generates 640x480@60 VGA timing from a 25 MHz pixel clock and schedules one VRAM byte read per 16 dot clocks on the display read port, which has 1-cycle registered latency. It unpacks each byte into four 2-bit pixels, each shown 4x wide and 4x tall, giving a 160x120 frame of 4800 bytes. Its `vblank` status tells the host interface when VRAM writes are tear-free.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_timing.sv | 73 +++++++
 rtl/vga_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_vga_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : 640x480@60 timing constants and VRAM geometry for the display
//            fetch path (4x4 pixel scaling, four 2-bit pixels per byte).
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int VRAM_AW = 13;

    typedef logic [9:0]         count_t;
    typedef logic [VRAM_AW-1:0] vaddr_t;

    localparam count_t H_VISIBLE = 10'd640;
    localparam count_t H_FRONT   = 10'd16;
    localparam count_t H_SYNC    = 10'd96;
    localparam count_t H_BACK    = 10'd48;
    localparam count_t H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam count_t V_VISIBLE = 10'd480;
    localparam count_t V_FRONT   = 10'd10;
    localparam count_t V_SYNC    = 10'd2;
    localparam count_t V_BACK    = 10'd33;
    localparam count_t V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int SCALE        = 4;
    localparam int PIX_PER_BYTE = 4;
    localparam int FETCH_PERIOD = SCALE * PIX_PER_BYTE;

    // A byte is addressed two dots before its group starts so that it can pass
    // through the registered VRAM port and into the shift register in time.
    localparam count_t     FETCH_LEAD  = 10'd2;
    localparam logic [3:0] FETCH_PHASE = 4'd14;
    localparam count_t     LAST_FETCH  = H_VISIBLE - count_t'(FETCH_PERIOD) - FETCH_LEAD;

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Brief    : Horizontal/vertical counters with pre-roll reset, sync/blank
//            decode of the current position and fetch/shift strobes for the
//            position about to be entered.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hNext,
    output logic [9:0] vCount,
    output logic       lineEnd,
    output logic       fetchSlot,
    output logic       fetchWrap,
    output logic       loadNext,
    output logic       shiftNext,
    output logic       visible,
    output logic       hsyncN,
    output logic       vsyncN,
    output logic       blankV,
    output logic       frameOrigin
);

    localparam count_t c_HS_START = H_VISIBLE + H_FRONT;
    localparam count_t c_HS_END   = c_HS_START + H_SYNC - 10'd1;
    localparam count_t c_VS_START = V_VISIBLE + V_FRONT;
    localparam count_t c_VS_END   = c_VS_START + V_SYNC - 10'd1;

    count_t r_h;
    count_t r_v;
    count_t w_vNext;

    always_comb begin
        lineEnd = (r_h == H_TOTAL - 10'd1);
        hNext   = lineEnd ? 10'd0 : r_h + 10'd1;
        w_vNext = r_v;
        if (lineEnd) begin
            w_vNext = (r_v == V_TOTAL - 10'd1) ? 10'd0 : r_v + 10'd1;
        end
    end

    // Pre-roll at (798, 524): the line-start fetch slot for line 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= H_TOTAL - 10'd2;
            r_v <= V_TOTAL - 10'd1;
        end else begin
            r_h <= hNext;
            r_v <= w_vNext;
        end
    end

    assign vCount    = r_v;
    assign fetchWrap = (hNext == H_TOTAL - 10'd2) &&
                       ((w_vNext == V_TOTAL - 10'd1) || (w_vNext < V_VISIBLE - 10'd1));
    assign fetchSlot = fetchWrap ||
                       ((hNext[3:0] == FETCH_PHASE) && (hNext <= LAST_FETCH) &&
                        (w_vNext < V_VISIBLE));
    assign loadNext  = (hNext[3:0] == 4'd0) && (hNext < H_VISIBLE) && (w_vNext < V_VISIBLE);
    assign shiftNext = (hNext[1:0] == 2'd0) && (hNext[3:2] != 2'd0);

    assign visible     = (r_h < H_VISIBLE) && (r_v < V_VISIBLE);
    assign hsyncN      = !((r_h >= c_HS_START) && (r_h <= c_HS_END));
    assign vsyncN      = !((r_v >= c_VS_START) && (r_v <= c_VS_END));
    assign blankV      = (r_v >= V_VISIBLE);
    assign frameOrigin = (r_h == 10'd0) && (r_v == 10'd0);

endmodule
`default_nettype wire

// File: rtl/vga_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_fetch_ctrl
// Brief    : Display-side VRAM fetch controller: line base tracking, read
//            address scheduling, byte unpacking and registered VGA outputs.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fetch_ctrl
    import vga_pkg::*;
#(
    parameter logic [12:0] BASE_ADDR      = 13'd0,
    parameter int          BYTES_PER_LINE = 40
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic [12:0] displayAddr,
    input  logic [7:0]  displayRdData,
    output logic        hsync,
    output logic        vsync,
    output logic        pixelValid,
    output logic [1:0]  pixel,
    output logic        vblank,
    output logic        frameStart
);

    localparam vaddr_t c_LINE_STRIDE = vaddr_t'(BYTES_PER_LINE);

    logic [9:0] w_hNext;
    logic [9:0] w_vCount;
    logic       w_lineEnd;
    logic       w_fetchSlot;
    logic       w_fetchWrap;
    logic       w_loadNext;
    logic       w_shiftNext;
    logic       w_visible;
    logic       w_hsyncN;
    logic       w_vsyncN;
    logic       w_blankV;
    logic       w_frameOrigin;

    vaddr_t     r_lineBase;
    vaddr_t     w_nextLineBase;
    count_t     w_target;
    vaddr_t     w_group;
    logic [7:0] r_shift;

    vga_timing u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .hNext       (w_hNext),
        .vCount      (w_vCount),
        .lineEnd     (w_lineEnd),
        .fetchSlot   (w_fetchSlot),
        .fetchWrap   (w_fetchWrap),
        .loadNext    (w_loadNext),
        .shiftNext   (w_shiftNext),
        .visible     (w_visible),
        .hsyncN      (w_hsyncN),
        .vsyncN      (w_vsyncN),
        .blankV      (w_blankV),
        .frameOrigin (w_frameOrigin)
    );

    // Base of the line following the current one; used both for the
    // line-start fetch at h=798 and for the line-end update.
    always_comb begin
        w_nextLineBase = r_lineBase;
        if (w_vCount == V_TOTAL - 10'd1) begin
            w_nextLineBase = BASE_ADDR;
        end else if ((w_vCount < V_VISIBLE) && (w_vCount[1:0] == 2'(SCALE - 1))) begin
            w_nextLineBase = r_lineBase + c_LINE_STRIDE;
        end
    end

    assign w_target = w_hNext + FETCH_LEAD;
    assign w_group  = vaddr_t'(w_target >> 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lineBase  <= BASE_ADDR;
            displayAddr <= BASE_ADDR;
            r_shift     <= 8'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            pixelValid  <= 1'b0;
            pixel       <= 2'd0;
            vblank      <= 1'b1;
            frameStart  <= 1'b0;
        end else begin
            if (w_lineEnd) begin
                r_lineBase <= w_nextLineBase;
            end

            if (w_fetchWrap) begin
                displayAddr <= w_nextLineBase;
            end else if (w_fetchSlot) begin
                displayAddr <= r_lineBase + w_group;
            end

            if (w_loadNext) begin
                r_shift <= displayRdData;
            end else if (w_shiftNext) begin
                r_shift <= {r_shift[5:0], 2'b00};
            end

            hsync      <= w_hsyncN;
            vsync      <= w_vsyncN;
            pixelValid <= w_visible;
            pixel      <= w_visible ? r_shift[7:6] : 2'd0;
            vblank     <= w_blankV;
            frameStart <= w_frameOrigin;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_fetch_ctrl
// Brief    : Self-checking bench for vga_fetch_ctrl with BASE_ADDR 0 and 8180.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fetch_ctrl;

    localparam int FRAME    = 800 * 525;
    localparam int PRE_ROLL = 524 * 800 + 798;
    localparam int BPL      = 40;
    localparam int BASE0    = 0;
    localparam int BASE1    = 8180;

    typedef struct packed {
        logic [12:0] addr;
        logic [1:0]  pix;
        logic        valid;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        vb;
    } obs_t;

    typedef struct {
        int k;
        int a0;
        int a1;
        int pix;
        bit valid;
        bit fs;
        bit hs;
        bit vb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] addr [2];
    logic [7:0]  rd [2];
    logic        hs [2];
    logic        vs [2];
    logic        pv [2];
    logic        vb [2];
    logic        fs [2];
    logic [1:0]  px [2];
    logic [7:0]  mem [2][8192];

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    always #20 clk = ~clk;

    vga_fetch_ctrl #(.BASE_ADDR(13'd0), .BYTES_PER_LINE(BPL)) dut0 (
        .clk(clk), .rst_n(rst_n), .displayAddr(addr[0]), .displayRdData(rd[0]),
        .hsync(hs[0]), .vsync(vs[0]), .pixelValid(pv[0]), .pixel(px[0]),
        .vblank(vb[0]), .frameStart(fs[0])
    );

    vga_fetch_ctrl #(.BASE_ADDR(13'd8180), .BYTES_PER_LINE(BPL)) dut1 (
        .clk(clk), .rst_n(rst_n), .displayAddr(addr[1]), .displayRdData(rd[1]),
        .hsync(hs[1]), .vsync(vs[1]), .pixelValid(pv[1]), .pixel(px[1]),
        .vblank(vb[1]), .frameStart(fs[1])
    );

    // VRAM display ports: one cycle registered read latency
    always @(posedge clk) begin
        rd[0] <= mem[0][addr[0]];
        rd[1] <= mem[1][addr[1]];
    end

    function automatic int baseOf(int d);
        return (d == 0) ? BASE0 : BASE1;
    endfunction

    function automatic obs_t sample(int d);
        obs_t o;
        o.addr = addr[d]; o.pix = px[d]; o.valid = pv[d]; o.fs = fs[d];
        o.hs = hs[d]; o.vs = vs[d]; o.vb = vb[d];
        return o;
    endfunction

    function automatic obs_t resetObs(int d);
        obs_t o;
        o.addr = 13'(baseOf(d)); o.pix = 2'd0; o.valid = 1'b0; o.fs = 1'b0;
        o.hs = 1'b1; o.vs = 1'b1; o.vb = 1'b1;
        return o;
    endfunction

    // Address the read port should present while the counters sit at L.
    function automatic logic [12:0] slotAddr(int base, int L, logic [12:0] hold);
        int h = L % 800;
        int v = L / 800;
        int nv = (v + 1) % 525;
        if ((h % 16 == 14) && (h <= 622) && (v < 480))
            return 13'((base + (v / 4) * BPL + (h + 2) / 16) % 8192);
        if ((h == 798) && (nv < 480))
            return 13'((base + (nv / 4) * BPL) % 8192);
        return hold;
    endfunction

    // Outputs describing screen position L.
    function automatic obs_t describe(int d, int L, logic [12:0] a);
        obs_t e;
        int h = L % 800;
        int v = L / 800;
        logic [7:0] b;
        b = mem[d][(baseOf(d) + (v / 4) * BPL + h / 16) % 8192];
        e.addr  = a;
        e.valid = (h < 640) && (v < 480);
        e.pix   = e.valid ? 2'(b >> (6 - 2 * ((h % 16) / 4))) : 2'd0;
        e.fs    = (h == 0) && (v == 0);
        e.hs    = !((h >= 656) && (h <= 751));
        e.vs    = !((v >= 490) && (v <= 491));
        e.vb    = (v >= 480);
        return e;
    endfunction

    task automatic check(string name, int d, int k, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d k=%0d: got addr=%0d pix=%0d valid=%b fs=%b hs=%b vs=%b vb=%b, expected addr=%0d pix=%0d valid=%b fs=%b hs=%b vs=%b vb=%b",
                     name, d, k, got.addr, got.pix, got.valid, got.fs, got.hs, got.vs, got.vb,
                     exp.addr, exp.pix, exp.valid, exp.fs, exp.hs, exp.vs, exp.vb);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Compare both DUTs against the reference model for a number of cycles
    // following a reset release (k = edges since release).
    task automatic runModel(int cycles);
        logic [12:0] ea [2];
        ea[0] = 13'(BASE0);
        ea[1] = 13'(BASE1);
        for (int k = 0; k < cycles; k++) begin
            if (k > 0) tick();
            for (int d = 0; d < 2; d++) begin
                ea[d] = slotAddr(baseOf(d), (PRE_ROLL + k) % FRAME, ea[d]);
                check("model", d, k, sample(d), describe(d, (PRE_ROLL + k - 1) % FRAME, ea[d]));
            end
        end
    endtask

    task automatic addVec(int k, int a0, int a1, int pix, bit valid, bit f, bit h, bit b);
        vec_t t;
        t.k = k; t.a0 = a0; t.a1 = a1; t.pix = pix; t.valid = valid; t.fs = f; t.hs = h; t.vb = b;
        vq.push_back(t);
    endtask

    initial begin
        int cur;
        obs_t e;

        for (int a = 0; a < 8192; a++) begin
            mem[0][a] = 8'(a);
            mem[1][a] = 8'($urandom);
        end
        mem[0][0] = 8'hE4;

        //      k     a0   a1    pix val fs hs vb
        addVec(0,    0,   8180, 0,  0,  0, 1, 1);
        addVec(1,    0,   8180, 0,  0,  0, 1, 1);
        addVec(2,    0,   8180, 0,  0,  0, 1, 1);
        addVec(3,    0,   8180, 3,  1,  1, 1, 0);
        addVec(6,    0,   8180, 3,  1,  0, 1, 0);
        addVec(7,    0,   8180, 2,  1,  0, 1, 0);
        addVec(11,   0,   8180, 1,  1,  0, 1, 0);
        addVec(15,   0,   8180, 0,  1,  0, 1, 0);
        addVec(16,   1,   8181, 0,  1,  0, 1, 0);
        addVec(19,   1,   8181, 0,  1,  0, 1, 0);
        addVec(27,   1,   8181, 0,  1,  0, 1, 0);
        addVec(31,   1,   8181, 1,  1,  0, 1, 0);
        addVec(32,   2,   8182, 1,  1,  0, 1, 0);
        addVec(192,  12,  0,    3,  1,  0, 1, 0);
        addVec(624,  39,  27,   2,  1,  0, 1, 0);
        addVec(642,  39,  27,   3,  1,  0, 1, 0);
        addVec(643,  39,  27,   0,  0,  0, 1, 0);
        addVec(658,  39,  27,   0,  0,  0, 1, 0);
        addVec(659,  39,  27,   0,  0,  0, 0, 0);
        addVec(754,  39,  27,   0,  0,  0, 0, 0);
        addVec(755,  39,  27,   0,  0,  0, 1, 0);
        addVec(800,  0,   8180, 0,  0,  0, 1, 0);
        addVec(803,  0,   8180, 3,  1,  0, 1, 0);
        addVec(3200, 40,  28,   0,  0,  0, 1, 0);
        addVec(3203, 40,  28,   0,  1,  0, 1, 0);
        addVec(3216, 41,  29,   0,  1,  0, 1, 0);
        addVec(3225, 41,  29,   2,  1,  0, 1, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check("reset", d, -1, sample(d), resetObs(d));

        // Hand-derived vectors after release
        release_reset();
        cur = 0;
        foreach (vq[i]) begin
            while (cur < vq[i].k) begin
                tick();
                cur++;
            end
            e.addr = 13'(vq[i].a0); e.pix = 2'(vq[i].pix); e.valid = vq[i].valid;
            e.fs = vq[i].fs; e.hs = vq[i].hs; e.vs = 1'b1; e.vb = vq[i].vb;
            check("table", 0, vq[i].k, sample(0), e);
            e = sample(1);
            e.addr = 13'(vq[i].a1);
            check("table_addr", 1, vq[i].k, sample(1), e);
        end

        // Fresh start, then whole-output comparison against the model
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check("reset2", d, -1, sample(d), resetObs(d));
        repeat (2) @(posedge clk);
        release_reset();
        runModel(6000);

        // Reset asserted at an arbitrary point inside a line
        repeat ($urandom_range(0, 799)) @(posedge clk);
        #($urandom_range(2, 18));
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check("async_reset", d, -1, sample(d), resetObs(d));
        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check("reset_hold", d, -1, sample(d), resetObs(d));
        release_reset();
        runModel(4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
